part_mode_debin: RTL and testbench

PART_MODE_DEBIN -- requirements
Module: part_mode_debin

---
 rtl/hevc_bin_pkg.sv | 32 +++
 rtl/part_mode_debin.sv | 128 ++++++++++++
 tb/tb_part_mode_debin.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hevc_bin_pkg.sv
// rtl/hevc_bin_pkg.sv - shared HEVC part_mode binarization types and constants
package hevc_bin_pkg;

  typedef enum logic [2:0] {
    PART_2NX2N = 3'd0,
    PART_2NXN  = 3'd1,
    PART_NX2N  = 3'd2,
    PART_NXN   = 3'd3,
    PART_2NXNU = 3'd4,
    PART_2NXND = 3'd5,
    PART_NLX2N = 3'd6,
    PART_NRX2N = 3'd7
  } part_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_FINISH = 2'd2
  } debin_state_e;

  // Bin-tree shape chosen once per request from the captured configuration
  typedef enum logic [1:0] {
    CLS_INTRA_MIN   = 2'd0,
    CLS_INTER_SHORT = 2'd1,
    CLS_INTER_NXN   = 2'd2,
    CLS_INTER_AMP   = 2'd3
  } bin_class_e;

  localparam logic PRED_INTRA = 1'b0;
  localparam logic PRED_INTER = 1'b1;

endpackage

// File: rtl/part_mode_debin.sv
// rtl/part_mode_debin.sv - part_mode syntax element de-binarizer
module part_mode_debin
  import hevc_bin_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] cu_size,
  input  logic [7:0] min_cu_size,
  input  logic       amp_enable,
  input  logic       pred_mode,
  input  logic       bin_valid,
  input  logic       bin_in,
  output logic       bin_ready,
  output logic [2:0] part_mode,
  output logic [2:0] bin_count,
  output logic       done,
  output logic       error
);

  debin_state_e state;
  bin_class_e   cls;
  bin_class_e   start_cls;
  logic [1:0]   bin_idx;
  logic [1:0]   bins_seen;
  logic         start_err;
  logic         start_direct;
  logic         dec_final;
  part_mode_e   dec_mode;

  always_comb begin
    start_err    = cu_size < min_cu_size;
    start_direct = start_err || (pred_mode == PRED_INTRA && cu_size > min_cu_size);
    if (pred_mode == PRED_INTRA)
      start_cls = CLS_INTRA_MIN;
    else if (cu_size == min_cu_size)
      start_cls = (cu_size == 8'd8) ? CLS_INTER_SHORT : CLS_INTER_NXN;
    else if (amp_enable)
      start_cls = CLS_INTER_AMP;
    else
      start_cls = CLS_INTER_SHORT;
  end

  // bins_seen[0] is the previous bin, bins_seen[1] the one before it
  always_comb begin
    dec_final = 1'b1;
    dec_mode  = PART_2NX2N;
    if (cls == CLS_INTRA_MIN) begin
      dec_mode = bin_in ? PART_2NX2N : PART_NXN;
    end else if (bin_idx == 2'd0) begin
      dec_final = bin_in;
    end else begin
      case (cls)
        CLS_INTER_SHORT: dec_mode = bin_in ? PART_2NXN : PART_NX2N;
        CLS_INTER_NXN: begin
          if (bin_idx == 2'd1) begin
            dec_final = bin_in;
            dec_mode  = PART_2NXN;
          end else begin
            dec_mode = bin_in ? PART_NX2N : PART_NXN;
          end
        end
        default: begin
          if (bin_idx == 2'd1) begin
            dec_final = 1'b0;
          end else if (bin_idx == 2'd2) begin
            dec_final = bin_in;
            dec_mode  = bins_seen[0] ? PART_2NXN : PART_NX2N;
          end else if (bins_seen[1]) begin
            dec_mode = bin_in ? PART_2NXND : PART_2NXNU;
          end else begin
            dec_mode = bin_in ? PART_NRX2N : PART_NLX2N;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cls       <= CLS_INTRA_MIN;
      bin_idx   <= 2'd0;
      bins_seen <= 2'd0;
      bin_ready <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      part_mode <= 3'd0;
      bin_count <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cls       <= start_cls;
            bin_idx   <= 2'd0;
            bins_seen <= 2'd0;
            error     <= start_err;
            part_mode <= PART_2NX2N;
            bin_count <= 3'd0;
            if (start_direct) begin
              state <= ST_FINISH;
              done  <= 1'b1;
            end else begin
              state     <= ST_DECODE;
              bin_ready <= 1'b1;
            end
          end
        end
        ST_DECODE: begin
          if (bin_valid) begin
            bins_seen <= {bins_seen[0], bin_in};
            bin_idx   <= bin_idx + 2'd1;
            if (dec_final) begin
              state     <= ST_FINISH;
              bin_ready <= 1'b0;
              done      <= 1'b1;
              part_mode <= dec_mode;
              bin_count <= {1'b0, bin_idx} + 3'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_part_mode_debin.sv
// tb/tb_part_mode_debin.sv - scoreboard bench for part_mode_debin
module tb_part_mode_debin;
  import hevc_bin_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] cu_size = 8'd8;
  logic [7:0] min_cu_size = 8'd8;
  logic       amp_enable = 1'b0;
  logic       pred_mode = 1'b0;
  logic       bin_valid = 1'b0;
  logic       bin_in = 1'b0;
  logic       bin_ready;
  logic [2:0] part_mode;
  logic [2:0] bin_count;
  logic       done;
  logic       error;

  part_mode_debin dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cu_size(cu_size),
    .min_cu_size(min_cu_size), .amp_enable(amp_enable), .pred_mode(pred_mode),
    .bin_valid(bin_valid), .bin_in(bin_in), .bin_ready(bin_ready),
    .part_mode(part_mode), .bin_count(bin_count), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] pm;
    logic [2:0] cnt;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("part_mode", {29'd0, part_mode}, {29'd0, mon_e.pm});
        check("bin_count", {29'd0, bin_count}, {29'd0, mon_e.cnt});
        check("error", {31'd0, error}, {31'd0, mon_e.err});
      end
    end
  end

  function automatic logic bin_model(input logic pred, input logic amp, input logic [7:0] cu,
                                     input logic [7:0] mn, input int pm,
                                     output logic [3:0] bits, output int len);
    logic ok;
    ok = 1'b1;
    bits = 4'b0000;
    len = 0;
    if (pred == PRED_INTRA) begin
      if (cu > mn) ok = (pm == 0);
      else if (pm == 0) begin bits = 4'b1000; len = 1; end
      else if (pm == 3) begin bits = 4'b0000; len = 1; end
      else ok = 1'b0;
    end else if (pm == 0) begin
      bits = 4'b1000; len = 1;
    end else if ((cu == mn && cu == 8'd8) || (cu > mn && !amp)) begin
      if (pm == 1) begin bits = 4'b0100; len = 2; end
      else if (pm == 2) begin bits = 4'b0000; len = 2; end
      else ok = 1'b0;
    end else if (cu == mn) begin
      if (pm == 1) begin bits = 4'b0100; len = 2; end
      else if (pm == 2) begin bits = 4'b0010; len = 3; end
      else if (pm == 3) begin bits = 4'b0000; len = 3; end
      else ok = 1'b0;
    end else begin
      case (pm)
        1: begin bits = 4'b0110; len = 3; end
        2: begin bits = 4'b0010; len = 3; end
        4: begin bits = 4'b0100; len = 4; end
        5: begin bits = 4'b0101; len = 4; end
        6: begin bits = 4'b0000; len = 4; end
        7: begin bits = 4'b0001; len = 4; end
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  task automatic push_exp(input logic [2:0] pm, input logic [2:0] cnt, input logic err);
    exp_t e;
    e.pm = pm;
    e.cnt = cnt;
    e.err = err;
    exp_q.push_back(e);
  endtask

  // Configuration inputs are scrambled after the start cycle to prove they were captured
  task automatic do_start(input logic pred, input logic amp, input logic [7:0] cu, input logic [7:0] mn);
    @(negedge clk);
    pred_mode = pred;
    amp_enable = amp;
    cu_size = cu;
    min_cu_size = mn;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pred_mode = ~pred;
    amp_enable = ~amp;
    cu_size = 8'hff;
    min_cu_size = 8'h00;
  endtask

  task automatic send_bin(input logic b, input int gap);
    int guard;
    guard = 0;
    repeat (gap) @(negedge clk);
    bin_valid = 1'b1;
    bin_in = b;
    while (!bin_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("bin_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bin_valid = 1'b0;
    bin_in = ~b;
  endtask

  task automatic run_case(input logic pred, input logic amp, input logic [7:0] cu, input logic [7:0] mn,
                          input logic [3:0] bits, input int len, input logic [2:0] pm,
                          input logic [2:0] cnt, input logic err, input int gap);
    push_exp(pm, cnt, err);
    do_start(pred, amp, cu, mn);
    if (len == 0) begin
      check("direct_done", {31'd0, done}, 32'd1);
      check("direct_ready", {31'd0, bin_ready}, 32'd0);
    end else begin
      for (int i = 0; i < len; i++)
        send_bin(bits[3-i], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
      check("done_latency", {31'd0, done}, 32'd1);
    end
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cu_tab [6];
    logic [7:0] mn_tab [6];
    logic [3:0] bits;
    int         len;
    cu_tab = '{8'd8, 8'd16, 8'd16, 8'd32, 8'd64, 8'd64};
    mn_tab = '{8'd8, 8'd8, 8'd16, 8'd16, 8'd64, 8'd8};

    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bin_ready}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pm", {29'd0, part_mode}, 32'd0);
    check("rst_cnt", {29'd0, bin_count}, 32'd0);
    check("rst_err", {31'd0, error}, 32'd0);

    // start presented together with reset release is taken on the first edge
    push_exp(3'd0, 3'd0, 1'b0);
    rst_n = 1'b1;
    pred_mode = PRED_INTRA;
    cu_size = 8'd16;
    min_cu_size = 8'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("first_start_done", {31'd0, done}, 32'd1);
    @(negedge clk);

    run_case(PRED_INTRA, 1'b0, 8'd8, 8'd8, 4'b0000, 1, 3'd3, 3'd1, 1'b0, 0);
    run_case(PRED_INTRA, 1'b0, 8'd8, 8'd8, 4'b1000, 1, 3'd0, 3'd1, 1'b0, 0);
    run_case(PRED_INTRA, 1'b1, 8'd16, 8'd8, 4'b0000, 0, 3'd0, 3'd0, 1'b0, 0);
    run_case(PRED_INTER, 1'b1, 8'd32, 8'd8, 4'b0101, 4, 3'd5, 3'd4, 1'b0, 3);
    run_case(PRED_INTER, 1'b0, 8'd16, 8'd16, 4'b0000, 3, 3'd3, 3'd3, 1'b0, 0);
    run_case(PRED_INTER, 1'b1, 8'd8, 8'd8, 4'b0000, 2, 3'd2, 3'd2, 1'b0, 20);
    run_case(PRED_INTER, 1'b0, 8'd8, 8'd16, 4'b0000, 0, 3'd0, 3'd0, 1'b1, 0);

    for (int p = 0; p < 2; p++)
      for (int a = 0; a < 2; a++)
        for (int k = 0; k < 6; k++)
          for (int pm = 0; pm < 8; pm++)
            if (bin_model(p[0], a[0], cu_tab[k], mn_tab[k], pm, bits, len))
              run_case(p[0], a[0], cu_tab[k], mn_tab[k], bits, len, pm[2:0], len[2:0], 1'b0, -1);

    // reset while a previous result is held, then mid-decode
    run_case(PRED_INTER, 1'b1, 8'd64, 8'd8, 4'b0001, 4, 3'd7, 3'd4, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    check("idle_rst_pm", {29'd0, part_mode}, 32'd0);
    check("idle_rst_cnt", {29'd0, bin_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    push_exp(3'd5, 3'd4, 1'b0);
    do_start(PRED_INTER, 1'b1, 8'd32, 8'd8);
    send_bin(1'b0, 0);
    send_bin(1'b1, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, bin_ready}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_err", {31'd0, error}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bin_valid = 1'b1;
    bin_in = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_ready", {31'd0, bin_ready}, 32'd0);
      check("post_rst_done", {31'd0, done}, 32'd0);
    end
    bin_valid = 1'b0;

    // second start while decoding must not disturb the decode
    push_exp(3'd3, 3'd3, 1'b0);
    do_start(PRED_INTER, 1'b0, 8'd16, 8'd16);
    send_bin(1'b0, 0);
    pred_mode = PRED_INTRA;
    cu_size = 8'd8;
    min_cu_size = 8'd16;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ignored_start_ready", {31'd0, bin_ready}, 32'd1);
    check("ignored_start_done", {31'd0, done}, 32'd0);
    send_bin(1'b0, 0);
    send_bin(1'b0, 0);
    check("ignored_start_latency", {31'd0, done}, 32'd1);
    @(negedge clk);

    run_case(PRED_INTRA, 1'b0, 8'd8, 8'd16, 4'b0000, 0, 3'd0, 3'd0, 1'b1, 0);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
